// File: rtl/vmem_pkg.sv
// Shared defaults and the write-buffer entry type for the vmem responder.
package vmem_pkg;
  localparam int VMEM_AW          = 8;
  localparam int VMEM_DW          = 8;
  localparam int VMEM_WB_DEPTH    = 4;
  localparam int VMEM_DRAIN_DELAY = 2;

  localparam int WB_CNT_W = $clog2(VMEM_WB_DEPTH + 1);
  localparam int AGE_W    = $clog2(VMEM_DRAIN_DELAY + 1);

  typedef struct packed {
    logic               valid;
    logic [VMEM_AW-1:0] addr;
    logic [VMEM_DW-1:0] data;
    logic [AGE_W-1:0]   age;
  } wb_entry_t;
endpackage

// File: rtl/vmem_if.sv
// Processor-side vmem request bus: posted write plus same-cycle read.
interface vmem_if
  import vmem_pkg::*;
#(
  parameter int AW = VMEM_AW,
  parameter int DW = VMEM_DW
);
  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;

  modport master (output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr,
                  input  mem_r_data);
  modport slave  (input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr,
                  output mem_r_data);
endinterface

// File: rtl/vmem_wbuf.sv
// Write-buffer FIFO: per-entry ageing, youngest-match read forwarding, head ripeness.
module vmem_wbuf
  import vmem_pkg::*;
#(
  parameter int WB_DEPTH    = VMEM_WB_DEPTH,
  parameter int DRAIN_DELAY = VMEM_DRAIN_DELAY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq,
  input  logic [VMEM_AW-1:0]  enq_addr,
  input  logic [VMEM_DW-1:0]  enq_data,
  input  logic                deq,
  input  logic [VMEM_AW-1:0]  rd_addr,
  output logic [VMEM_AW-1:0]  head_addr,
  output logic [VMEM_DW-1:0]  head_data,
  output logic                head_ripe,
  output logic                full,
  output logic [WB_CNT_W-1:0] count,
  output logic                hit,
  output logic [VMEM_DW-1:0]  hit_data
);
  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

  wb_entry_t        ent [WB_DEPTH];
  logic [PTR_W-1:0] head, tail;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // When full, deq and enq hit the same slot; the enqueue is applied last so it wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WB_DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < WB_DEPTH; i++)
        if (ent[i].valid && ent[i].age != AGE_W'(DRAIN_DELAY))
          ent[i].age <= ent[i].age + 1'b1;
      if (deq) begin
        ent[head].valid <= 1'b0;
        head            <= nxt(head);
      end
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, addr: enq_addr, data: enq_data, age: '0};
        tail      <= nxt(tail);
      end
      count <= count + WB_CNT_W'(enq) - WB_CNT_W'(deq);
    end
  end

  assign full      = (count == WB_CNT_W'(WB_DEPTH));
  assign head_addr = ent[head].addr;
  assign head_data = ent[head].data;
  assign head_ripe = ent[head].valid && (ent[head].age == AGE_W'(DRAIN_DELAY));

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    int idx;
    idx      = 0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = (int'(head) + i) % WB_DEPTH;
      if (ent[idx].valid && ent[idx].addr == rd_addr) begin
        hit      = 1'b1;
        hit_data = ent[idx].data;
      end
    end
  end
endmodule

// File: rtl/vmem_resp.sv
// vmem responder: backing array, commit arbitration, read mux.
// VMEM_RESET_CLEAR_EN: async reset also zeroes the array.
module vmem_resp
  import vmem_pkg::*;
#(
  parameter int AW          = VMEM_AW,
  parameter int DW          = VMEM_DW,
  parameter int WB_DEPTH    = VMEM_WB_DEPTH,
  parameter int DRAIN_DELAY = VMEM_DRAIN_DELAY
) (
  input  logic                clk,
  input  logic                rst,
  vmem_if.slave               bus,
  output logic [WB_CNT_W-1:0] wb_count,
  output logic                wb_full,
  output logic                commit_valid
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data, hit_data;
  logic          head_ripe, hit, commit;

  vmem_wbuf #(.WB_DEPTH(WB_DEPTH), .DRAIN_DELAY(DRAIN_DELAY)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .enq       (bus.mem_w_en),
    .enq_addr  (bus.mem_w_addr),
    .enq_data  (bus.mem_w_data),
    .deq       (commit),
    .rd_addr   (bus.mem_r_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_ripe (head_ripe),
    .full      (wb_full),
    .count     (wb_count),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  // A read owns the array port unless a full buffer must make room for a write.
  assign commit = (head_ripe && !bus.mem_r_en) || (wb_full && bus.mem_w_en);

`ifdef VMEM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[head_addr] <= head_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (commit) mem[head_addr] <= head_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) commit_valid <= 1'b0;
    else      commit_valid <= commit;
  end

  assign bus.mem_r_data = !bus.mem_r_en ? '0 :
                          hit           ? hit_data : mem[bus.mem_r_addr];
endmodule

// File: doc/vmem_resp.md
Name: vmem_resp

Overview:
- Memory responder that serves the processor-side vmem request interface: write enable/address/data, and read enable/address with same-cycle read data.
- Writes are posted into a small FIFO write buffer and committed to the backing array after a fixed drain delay.
- Reads forward from the buffer, youngest match first, so the buffering is invisible to the requester.
- Sits between the processor core and the abstract memory model used by the vpipe/vmem refinement tests.

Parameters:
- AW, 8, address width; the array holds 2**AW entries.
- DW, 8, data width.
- WB_DEPTH, 4, write-buffer entries (>=1).
- DRAIN_DELAY, 2, minimum cycles an entry waits in the buffer before it may commit (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- mem_w_en  input  1  write request this cycle.
- mem_w_addr  input  AW  write address.
- mem_w_data  input  DW  write data.
- mem_r_en  input  1  read request this cycle; also marks the array port busy.
- mem_r_addr  input  AW  read address.
- mem_r_data  output  DW  combinational read data.
- wb_count  output  $clog2(WB_DEPTH+1)  buffered entries, registered.
- wb_full  output  1  wb_count==WB_DEPTH.
- commit_valid  output  1  registered pulse: an entry committed to the array on the previous edge.

Behaviour:
- Reset (rst low, async): buffer emptied; head/tail pointers, all ages and commit_valid go to 0; wb_count=0; wb_full=0. Reset mid-drain discards all uncommitted writes.
- Array contents are unaffected by reset unless VMEM_RESET_CLEAR_EN is defined.
- Enqueue: on each edge with mem_w_en=1, {addr,data} is appended at the tail with age 0. No coalescing; repeated writes to one address occupy separate entries.
- Age: each valid entry's age increments by 1 per cycle, saturating at DRAIN_DELAY.
- Commit (at most one per cycle, always the head entry), head written to the array on the edge when either:
  - normal: head age==DRAIN_DELAY and mem_r_en=0; or
  - forced: wb_full=1 and mem_w_en=1, regardless of mem_r_en or age.
- Full plus write: forced commit and enqueue happen on the same edge, so wb_count stays WB_DEPTH and no write is ever dropped.
- Pointers wrap modulo WB_DEPTH.
- wb_count next value = count + enqueue - commit.
- commit_valid is 1 for exactly the cycle after each commit.
- Read data (combinational, whenever mem_r_en=1):
  - Returns the youngest valid buffer entry whose addr==mem_r_addr; otherwise returns array[mem_r_addr].
  - A same-cycle write to the same address is not visible; the read returns the pre-edge value.
  - mem_r_data=0 when mem_r_en=0.
- Commit with a simultaneous read of the same address: the read sees the entry still in the buffer, so the value is the same either way.
- Both mem_w_en and mem_r_en high in one cycle is legal: read as above, write enqueued.
- Widths: addresses and data are pass-through. No arithmetic beyond pointer/age/count updates, which wrap or saturate as stated.

Optional Feature:
- Macro VMEM_RESET_CLEAR_EN.
- Defined: asynchronous reset also clears every array entry to 0, so reads after reset return 0.
- Undefined: array has no reset; a never-written location reads X in simulation. Benches must write a location before checking it.

Decomposition:
- Package vmem_pkg holds:
  - AW/DW defaults;
  - typedef wb_entry_t {logic valid; logic [AW-1:0] addr; logic [DW-1:0] data; age counter};
  - constant WB_CNT_W = $clog2(WB_DEPTH+1).
- One natural sub-module: vmem_wbuf (FIFO, ages, forwarding match, commit request).
- Top vmem_resp holds the array, the commit arbitration and the output mux.

Test Plan:
- Reset then write 0x10<-0xAB at t0, idle -> wb_count=1 at t1; commit edge at t0+DRAIN_DELAY+1; commit_valid pulses the cycle after; read 0x10 returns 0xAB before and after the commit.
- Write 0x20<-0x01, then 0x20<-0x02 on consecutive cycles, read 0x20 next cycle -> 0x02 (youngest forwarded); after both drain, array[0x20]=0x02.
- Hold mem_r_en=1 (addr 0x00) for 10 cycles after one write -> no commit while the read is active; commit occurs on the first cycle mem_r_en=0.
- With mem_r_en held high, issue 5 writes (WB_DEPTH=4) to 0x30..0x34 -> 5th write forces commit of 0x30; wb_count stays 4; all five values read back correctly.
- Buffer holding 3 entries, assert rst low mid-cycle -> wb_count=0 and wb_full=0 immediately. With VMEM_RESET_CLEAR_EN defined, reads of those addresses return 0x00.
- Same-cycle write 0x40<-0x55 and read 0x40 (prior value 0x11 committed) -> mem_r_data=0x11 that cycle, 0x55 the next.
